// File: rtl/vdcm_pkg.sv
//------------------------------------------------------------------------------
// Module  : vdcm_pkg
// Brief   : Shared constants and helpers for the substream mux-word feeder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vdcm_pkg;

    localparam int NUM_SSM    = 4;
    localparam int MUX_WORD_W = 128;

    // Number of set bits in a 4-bit vector (0..4).
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ssm_word_ring.sv
//------------------------------------------------------------------------------
// Module  : ssm_word_ring
// Brief   : Circular word buffer with one write port and NUM_SSM combinational
//           read ports at rd_ptr+0..NUM_SSM-1; tracks pointers and occupancy.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ssm_word_ring
    import vdcm_pkg::*;
#(
    parameter int WORD_W = 128,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WORD_W-1:0]           push_data,
    input  logic [2:0]                  n_pop,
    output logic [OCC_W-1:0]            count,
    output logic [NUM_SSM*WORD_W-1:0]   rd_words
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr + PTR_W'(n_pop);
            count  <= count + OCC_W'(push) - OCC_W'(n_pop);
        end
    end

    // Word storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head words, in bitstream order, for the grant logic.
    for (genvar k = 0; k < NUM_SSM; k++) begin : g_rd
        assign rd_words[k*WORD_W +: WORD_W] = mem[rd_ptr + PTR_W'(k)];
    end

endmodule

`default_nettype wire

// File: rtl/ssm_mux_word_feeder.sv
//------------------------------------------------------------------------------
// Module  : ssm_mux_word_feeder
// Brief   : Buffers rate-buffer mux words and hands the head words to the
//           requesting substream parsers in fixed priority order ssm0..ssm3.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ssm_mux_word_feeder #(
    parameter int MUX_WORD_W = vdcm_pkg::MUX_WORD_W,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   flush,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [MUX_WORD_W-1:0]                  in_data,
    input  logic [vdcm_pkg::NUM_SSM-1:0]           ssm_rd_en,
    output logic [vdcm_pkg::NUM_SSM-1:0]           ssm_gnt,
    output logic [vdcm_pkg::NUM_SSM*MUX_WORD_W-1:0] ssm_data,
    output logic [CNT_W-1:0]                       words_served,
    output logic [CNT_W-1:0]                       stall_cycles
);

    import vdcm_pkg::*;

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [OCC_W-1:0]              count;
    logic [NUM_SSM*MUX_WORD_W-1:0] rd_words;
    logic [MUX_WORD_W-1:0]         word_at [NUM_SSM];
    logic                          push;
    logic [2:0]                    n_pop;

    // Push decoded from registered occupancy only, so a pop never frees a slot
    // for a push in the same cycle; flush blocks both sides.
    assign in_ready = (count < OCC_W'(DEPTH)) & ~flush;
    assign push     = in_valid & in_ready;
    assign n_pop    = popcount4(ssm_gnt);

    ssm_word_ring #(
        .WORD_W (MUX_WORD_W),
        .DEPTH  (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .push      (push),
        .push_data (in_data),
        .n_pop     (n_pop),
        .count     (count),
        .rd_words  (rd_words)
    );

    // Rank counts lower requests (not lower grants), so words leave strictly in
    // bitstream order and a starved requester starves everyone above it.
    for (genvar k = 0; k < NUM_SSM; k++) begin : g_ssm
        localparam logic [3:0] LOWER = 4'((1 << k) - 1);
        logic [2:0] rank;

        assign word_at[k] = rd_words[k*MUX_WORD_W +: MUX_WORD_W];
        assign rank       = popcount4(ssm_rd_en & LOWER);
        assign ssm_gnt[k] = ssm_rd_en[k] & (OCC_W'(rank) < count) & ~flush;
        assign ssm_data[k*MUX_WORD_W +: MUX_WORD_W] =
            ssm_gnt[k] ? word_at[rank[1:0]] : '0;
    end

    // Status counters: words popped (wrapping) and stalled cycles (saturating).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            words_served <= '0;
            stall_cycles <= '0;
        end else begin
            if (flush) begin
                words_served <= '0;
            end else begin
                words_served <= words_served + CNT_W'(n_pop);
            end
            if ((|(ssm_rd_en & ~ssm_gnt)) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ssm_mux_word_feeder.sv
//------------------------------------------------------------------------------
// Module  : tb_ssm_mux_word_feeder
// Brief   : Directed self-checking bench for ssm_mux_word_feeder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ssm_mux_word_feeder;

    logic         clk;
    logic         rstn;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rd_en;
    logic [3:0]   gnt;
    logic [511:0] data;
    logic [15:0]  words_served;
    logic [15:0]  stall_cycles;

    int errors = 0;
    int checks = 0;

    int           exp_stall;
    int           exp_ws;
    logic [511:0] exp_data;
    logic [3:0]   exp_gnt;
    logic [127:0] q [$];
    int           pushed;
    int           cyc;
    int           rank;
    int           npop;
    logic         exp_ready;

    ssm_mux_word_feeder #(
        .MUX_WORD_W (128),
        .DEPTH      (8),
        .CNT_W      (16)
    ) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .ssm_rd_en    (rd_en),
        .ssm_gnt      (gnt),
        .ssm_data     (data),
        .words_served (words_served),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [127:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; rd_en = '0;
        exp_stall = 0; exp_ws = 0;

        // Reset state
        #12;
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_gnt", 512'(gnt), 512'(0));
        chk("rst_data", data, 512'(0));
        chk("rst_ws", 512'(words_served), 512'(0));
        chk("rst_stall", 512'(stall_cycles), 512'(0));
        rstn = 1'b1;
        tick();

        // 1: four words, all four requesters in one cycle
        for (int i = 0; i < 4; i++) push_word(128'(i));
        rd_en = 4'hF; #1;
        chk("t1_gnt", 512'(gnt), 512'hF);
        chk("t1_data", data, {128'd3, 128'd2, 128'd1, 128'd0});
        tick(); rd_en = 4'h0; #1;
        chk("t1_ws", 512'(words_served), 512'(4));
        rd_en = 4'h1; #1;
        chk("t1_empty_gnt", 512'(gnt), 512'(0));
        chk("t1_empty_data", data, 512'(0));
        tick(); rd_en = 4'h0; exp_stall = 1; #1;
        chk("t1_stall", 512'(stall_cycles), 512'(exp_stall));

        // 2: two words, rd_en=1011 -> ssm3 starved
        push_word(128'd4); push_word(128'd5);
        rd_en = 4'b1011; #1;
        chk("t2_gnt", 512'(gnt), 512'b0011);
        chk("t2_data", data, {128'd0, 128'd0, 128'd5, 128'd4});
        tick(); rd_en = 4'h0; exp_stall = 2; #1;
        chk("t2_stall", 512'(stall_cycles), 512'(exp_stall));
        chk("t2_ws", 512'(words_served), 512'(6));

        // A word pushed this cycle is not grantable this cycle
        in_valid = 1'b1; in_data = 128'd6; rd_en = 4'h1; #1;
        chk("nopass_gnt", 512'(gnt), 512'(0));
        tick(); in_valid = 1'b0; exp_stall = 3; #1;
        chk("nopass_next_gnt", 512'(gnt), 512'(1));
        chk("nopass_next_data", data, 512'(128'd6));
        tick(); rd_en = 4'h0; #1;
        chk("nopass_ws", 512'(words_served), 512'(7));

        // 3: fill to DEPTH, then pop with in_valid held
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t3_fill_ready", 512'(in_ready), 512'(1));
            push_word(128'(8 + i));
        end
        #1;
        chk("t3_full_ready", 512'(in_ready), 512'(0));
        in_valid = 1'b1; in_data = 128'd16; rd_en = 4'h1; #1;
        chk("t3_full_pop_ready", 512'(in_ready), 512'(0));
        chk("t3_full_pop_gnt", 512'(gnt), 512'(1));
        chk("t3_full_pop_data", data, 512'(128'd8));
        tick(); rd_en = 4'h0; #1;
        chk("t3_ready_back", 512'(in_ready), 512'(1));
        chk("t3_ws", 512'(words_served), 512'(8));
        tick(); in_valid = 1'b0; #1;
        chk("t3_full_again", 512'(in_ready), 512'(0));
        rd_en = 4'hF; #1;
        chk("t3_drain1", data, {128'd12, 128'd11, 128'd10, 128'd9});
        tick(); #1;
        chk("t3_drain2_gnt", 512'(gnt), 512'hF);
        chk("t3_drain2", data, {128'd16, 128'd15, 128'd14, 128'd13});
        tick(); rd_en = 4'h0; #1;
        chk("t3_ws_end", 512'(words_served), 512'(16));
        chk("t3_stall", 512'(stall_cycles), 512'(exp_stall));
        exp_ws = 16;

        // 4: 40 words with random requests across pointer wraps
        pushed = 0; cyc = 0;
        while ((pushed < 40 || q.size() > 0) && cyc < 2000) begin
            rd_en    = 4'($urandom_range(0, 15));
            in_valid = (pushed < 40) && ($urandom_range(0, 3) != 0);
            in_data  = 128'h100 + 128'(pushed);
            #1;
            exp_gnt = '0; exp_data = '0; rank = 0;
            for (int k = 0; k < 4; k++) begin
                if (rd_en[k]) begin
                    if (rank < q.size()) begin
                        exp_gnt[k] = 1'b1;
                        exp_data[k*128 +: 128] = q[rank];
                    end
                    rank++;
                end
            end
            exp_ready = (q.size() < 8);
            chk("t4_gnt", 512'(gnt), 512'(exp_gnt));
            chk("t4_data", data, exp_data);
            chk("t4_ready", 512'(in_ready), 512'(exp_ready));
            if ((rd_en & ~exp_gnt) != 4'h0) exp_stall++;
            tick();
            npop = $countones(exp_gnt);
            for (int j = 0; j < npop; j++) void'(q.pop_front());
            exp_ws += npop;
            if (in_valid && exp_ready) begin
                q.push_back(in_data);
                pushed++;
            end
            cyc++;
        end
        rd_en = 4'h0; in_valid = 1'b0; #1;
        chk("t4_budget", 512'(cyc < 2000), 512'(1));
        chk("t4_ws", 512'(words_served), 512'(exp_ws));
        chk("t4_stall", 512'(stall_cycles), 512'(exp_stall));

        // 5: flush with requests and a push offered
        for (int i = 0; i < 5; i++) push_word(128'h200 + 128'(i));
        flush = 1'b1; rd_en = 4'hF; in_valid = 1'b1; in_data = 128'h205; #1;
        chk("t5_flush_gnt", 512'(gnt), 512'(0));
        chk("t5_flush_ready", 512'(in_ready), 512'(0));
        chk("t5_flush_data", data, 512'(0));
        tick(); exp_stall++;
        flush = 1'b0; rd_en = 4'h0; in_valid = 1'b0; #1;
        chk("t5_ws", 512'(words_served), 512'(0));
        chk("t5_ready", 512'(in_ready), 512'(1));
        rd_en = 4'h1; #1;
        chk("t5_empty_gnt", 512'(gnt), 512'(0));
        tick(); rd_en = 4'h0; exp_stall++; #1;
        chk("t5_stall", 512'(stall_cycles), 512'(exp_stall));

        // 6: asynchronous reset mid-stream with three words held
        for (int i = 0; i < 3; i++) push_word(128'h300 + 128'(i));
        rd_en = 4'hF; #1;
        chk("t6_pre_gnt", 512'(gnt), 512'b0111);
        rstn = 1'b0; #1;
        chk("t6_rst_gnt", 512'(gnt), 512'(0));
        chk("t6_rst_data", data, 512'(0));
        chk("t6_rst_ready", 512'(in_ready), 512'(1));
        chk("t6_rst_ws", 512'(words_served), 512'(0));
        chk("t6_rst_stall", 512'(stall_cycles), 512'(0));
        #2; rstn = 1'b1; rd_en = 4'h0;
        tick();
        push_word(128'h400);
        rd_en = 4'h1; #1;
        chk("t6_post_gnt", 512'(gnt), 512'(1));
        chk("t6_post_data", data, 512'(128'h400));
        tick(); rd_en = 4'h0; #1;
        chk("t6_post_ws", 512'(words_served), 512'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
